// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer.
//   ROB_TAG_W : tag width, ROB_DEPTH = 2**ROB_TAG_W entries
//   N_PHYS    : physical register count, PREG_W bits per preg id
//   N_CMP     : number of writeback (completion) ports
//   rob_entry_t : per-entry bookkeeping {valid, done, rd_used, old_p, new_p}
package reorder_buffer_pkg;
  localparam int ROB_TAG_W = 4;
  localparam int ROB_DEPTH = 2 ** ROB_TAG_W;
  localparam int N_PHYS    = 64;
  localparam int PREG_W    = $clog2(N_PHYS);
  localparam int N_CMP     = 3;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              rd_used;
    logic [PREG_W-1:0] old_p;
    logic [PREG_W-1:0] new_p;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Rename allocates one entry per tag at the tail,
// functional units mark entries done by tag, the oldest done entry retires
// (one per cycle) and returns its previous rd mapping to the rename free list.
// A mispredict recovery discards every entry from recover_tag_i to the tail.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_*                  allocation handshake from rename (tag must equal tail)
//   cmp_valid_i/cmp_tag_i    N_CMP writeback ports (tag per port, packed)
//   recover_i/recover_tag_i  flush pulse, first tag to discard
//   commit_*                 registered retirement pulse (tag, new preg)
//   rob_commit_free_*        registered free-list return (old preg)
//   empty_o                  no entries in flight
// Build option ROB_PERF_CNT_EN adds perf_committed_o, perf_flushed_o and
// perf_full_cycles_o (32-bit wrapping event counters).
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic [ROB_TAG_W-1:0]       alloc_tag_i,
  input  logic                       alloc_rd_used_i,
  input  logic [PREG_W-1:0]          alloc_rd_old_p_i,
  input  logic [PREG_W-1:0]          alloc_rd_new_p_i,
  input  logic [N_CMP-1:0]           cmp_valid_i,
  input  logic [N_CMP*ROB_TAG_W-1:0] cmp_tag_i,
  input  logic                       recover_i,
  input  logic [ROB_TAG_W-1:0]       recover_tag_i,
  output logic                       commit_valid_o,
  output logic [ROB_TAG_W-1:0]       commit_tag_o,
  output logic [PREG_W-1:0]          commit_rd_new_p_o,
  output logic                       rob_commit_free_valid_o,
  output logic [PREG_W-1:0]          rob_commit_free_preg_o,
  output logic                       empty_o
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_committed_o,
  output logic [31:0]                perf_flushed_o,
  output logic [31:0]                perf_full_cycles_o
`endif
);
  localparam int CNT_W = ROB_TAG_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(ROB_DEPTH);
  typedef logic [ROB_TAG_W-1:0] tag_t;

  rob_entry_t [ROB_DEPTH-1:0] ent_q, ent_d;
  tag_t                       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       alloc_fire, can_commit;
  logic [ROB_DEPTH-1:0]       squash;
  tag_t                       rec_dist;

  logic                       commit_valid_q, free_valid_q;
  tag_t                       commit_tag_q;
  logic [PREG_W-1:0]          commit_new_p_q, free_preg_q;

  assign alloc_ready_o = (count_q < DEPTH_C) && !recover_i;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign empty_o       = (count_q == '0);

  assign can_commit = (count_q != '0) && ent_q[head_q].valid && ent_q[head_q].done &&
                      !(recover_i && (head_q == recover_tag_i));

  // Squash by age relative to head rather than by comparing against tail,
  // so a full buffer (tail == head) still resolves which entries to drop.
  assign rec_dist = recover_tag_i - head_q;
  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_sq
    tag_t off;
    assign off       = tag_t'(i) - head_q;
    assign squash[i] = recover_i && (off >= rec_dist) && ({1'b0, off} < count_q);
  end

  always_comb begin
    ent_d = ent_q;
    for (int p = 0; p < N_CMP; p++) begin
      if (cmp_valid_i[p] && ent_q[cmp_tag_i[p*ROB_TAG_W +: ROB_TAG_W]].valid)
        ent_d[cmp_tag_i[p*ROB_TAG_W +: ROB_TAG_W]].done = 1'b1;
    end
    if (can_commit) begin
      ent_d[head_q].valid = 1'b0;
      ent_d[head_q].done  = 1'b0;
    end
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (squash[i]) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
    end
    // alloc_fire already excludes recovery cycles
    if (alloc_fire) begin
      ent_d[tail_q].valid   = 1'b1;
      ent_d[tail_q].done    = 1'b0;
      ent_d[tail_q].rd_used = alloc_rd_used_i;
      ent_d[tail_q].old_p   = alloc_rd_old_p_i;
      ent_d[tail_q].new_p   = alloc_rd_new_p_i;
    end
  end

  always_comb begin
    head_d  = head_q + {{(ROB_TAG_W-1){1'b0}}, can_commit};
    tail_d  = tail_q + {{(ROB_TAG_W-1){1'b0}}, alloc_fire};
    count_d = count_q;
    if (recover_i) begin
      tail_d  = recover_tag_i;
      count_d = {1'b0, tag_t'(recover_tag_i - head_d)};
    end else if (alloc_fire && !can_commit) begin
      count_d = count_q + CNT_W'(1);
    end else if (!alloc_fire && can_commit) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_new_p_q <= '0;
      free_valid_q   <= 1'b0;
      free_preg_q    <= '0;
    end else begin
      ent_q          <= ent_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= can_commit;
      commit_tag_q   <= can_commit ? head_q : '0;
      commit_new_p_q <= can_commit ? ent_q[head_q].new_p : '0;
      // preg 0 is never a real free-list entry
      free_valid_q   <= can_commit && ent_q[head_q].rd_used && (ent_q[head_q].old_p != '0);
      free_preg_q    <= can_commit ? ent_q[head_q].old_p : '0;
    end
  end

  assign commit_valid_o          = commit_valid_q;
  assign commit_tag_o            = commit_tag_q;
  assign commit_rd_new_p_o       = commit_new_p_q;
  assign rob_commit_free_valid_o = free_valid_q;
  assign rob_commit_free_preg_o  = free_preg_q;

`ifdef ROB_PERF_CNT_EN
  logic [CNT_W-1:0] flush_cnt;
  logic [31:0]      perf_committed_q, perf_flushed_q, perf_full_q;

  always_comb begin
    flush_cnt = '0;
    for (int i = 0; i < ROB_DEPTH; i++)
      flush_cnt = flush_cnt + CNT_W'(squash[i] && ent_q[i].valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_committed_q <= '0;
      perf_flushed_q   <= '0;
      perf_full_q      <= '0;
    end else begin
      perf_committed_q <= perf_committed_q + 32'(can_commit);
      perf_flushed_q   <= perf_flushed_q + 32'(flush_cnt);
      perf_full_q      <= perf_full_q + 32'(count_q == DEPTH_C);
    end
  end

  assign perf_committed_o   = perf_committed_q;
  assign perf_flushed_o     = perf_flushed_q;
  assign perf_full_cycles_o = perf_full_q;
`endif

  a_alloc_tag: assert property (@(posedge clk) disable iff (rst)
    alloc_fire |-> (alloc_tag_i == tail_q));

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a queue-of-in-flight-instructions model predicts
// ready/empty/commit/free every cycle, plus hand-computed literal checks.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_v = 1'b0, a_used = 1'b0;
  logic [3:0]  a_tag = '0;
  logic [5:0]  a_old = '0, a_new = '0;
  logic [2:0]  c_v = '0;
  logic [11:0] c_tag = '0;
  logic        rec = 1'b0;
  logic [3:0]  rtag = '0;

  logic       ready, cv, fv, empty;
  logic [3:0] ctag;
  logic [5:0] cnewp, fpreg;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(a_v), .alloc_ready_o(ready), .alloc_tag_i(a_tag),
    .alloc_rd_used_i(a_used), .alloc_rd_old_p_i(a_old), .alloc_rd_new_p_i(a_new),
    .cmp_valid_i(c_v), .cmp_tag_i(c_tag),
    .recover_i(rec), .recover_tag_i(rtag),
    .commit_valid_o(cv), .commit_tag_o(ctag), .commit_rd_new_p_o(cnewp),
    .rob_commit_free_valid_o(fv), .rob_commit_free_preg_o(fpreg),
    .empty_o(empty)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model: program-order list of in-flight instructions
  typedef struct { int tag; bit done; bit used; int oldp; int newp; } m_ent_t;
  m_ent_t mq[$];
  int     m_tail = 0;
  bit     e_cv = 0, e_fv = 0, chk_en = 0;
  int     e_ctag = 0, e_newp = 0, e_fp = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_tail = 0;
      e_cv = 0;
      e_fv = 0;
      chk_en = 1;
    end else begin
      int idx;
      m_ent_t ne;
      e_cv = 0;
      e_fv = 0;
      // oldest retires if it finished in an earlier cycle and is not being flushed
      if (mq.size() > 0 && mq[0].done && !(rec && mq[0].tag == int'(rtag))) begin
        e_cv   = 1;
        e_ctag = mq[0].tag;
        e_newp = mq[0].newp;
        e_fv   = mq[0].used && mq[0].oldp != 0;
        e_fp   = mq[0].oldp;
        void'(mq.pop_front());
      end
      for (int p = 0; p < 3; p++)
        if (c_v[p])
          foreach (mq[k]) if (mq[k].tag == int'(c_tag[p*4 +: 4])) mq[k].done = 1;
      if (rec) begin
        idx = -1;
        foreach (mq[k]) if (mq[k].tag == int'(rtag) && idx < 0) idx = k;
        if (idx >= 0) while (mq.size() > idx) void'(mq.pop_back());
        m_tail = int'(rtag);
      end else if (a_v && mq.size() < 16) begin
        ne.tag = int'(a_tag); ne.done = 0; ne.used = a_used;
        ne.oldp = int'(a_old); ne.newp = int'(a_new);
        mq.push_back(ne);
        m_tail = (m_tail + 1) % 16;
      end
    end
  end

  // ---------------- compare process
  int ctags[$], frees[$];
  always @(negedge clk) begin
    if (chk_en) begin
      chk("alloc_ready", ready, (mq.size() < 16 && !rec));
      chk("empty", empty, (mq.size() == 0));
      chk("commit_valid", cv, e_cv);
      chk("free_valid", fv, e_fv);
      if (e_cv) begin
        chk("commit_tag", ctag, e_ctag);
        chk("commit_new_p", cnewp, e_newp);
      end
      if (e_fv) chk("free_preg", fpreg, e_fp);
      if (cv) ctags.push_back(int'(ctag));
      if (fv) frees.push_back(int'(fpreg));
    end
  end

  // ---------------- driver helpers
  task automatic tick();
    @(posedge clk); #1;
    a_v = 0; c_v = '0; rec = 0;
  endtask
  task automatic wait_n(int n); repeat (n) tick(); endtask
  task automatic set_alloc(bit used, int oldp, int newp);
    a_v = 1; a_tag = 4'(m_tail); a_used = used; a_old = 6'(oldp); a_new = 6'(newp);
  endtask
  task automatic do_alloc(bit used, int oldp, int newp);
    set_alloc(used, oldp, newp); tick();
  endtask
  task automatic set_cmp(int port, int tag);
    c_v[port] = 1'b1; c_tag[port*4 +: 4] = 4'(tag);
  endtask
  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
    ctags.delete(); frees.delete();
  endtask

  initial begin
    tick();
    // 1. basic retire, frees 5,6,7 back to back, first-commit latency
    do_reset();
    do_alloc(1, 5, 40); do_alloc(1, 6, 41); do_alloc(1, 7, 42);
    set_cmp(0, 0); set_cmp(1, 1); set_cmp(2, 2); tick();
    @(negedge clk); chk("t1_no_commit_yet", cv, 0);
    tick();
    @(negedge clk); chk("t1_first_commit", cv, 1);
    wait_n(5);
    chk("t1_free_count", frees.size(), 3);
    if (frees.size() == 3) begin
      chk("t1_free0", frees[0], 5); chk("t1_free1", frees[1], 6); chk("t1_free2", frees[2], 7);
    end

    // 2. fill to 16, ready drops; one completion frees one slot
    do_reset();
    for (int k = 0; k < 16; k++) do_alloc(1, k + 1, k + 20);
    chk("t2_model_full", mq.size(), 16);
    @(negedge clk); chk("t2_full_ready", ready, 0);
    set_cmp(0, 0); tick();
    @(negedge clk); chk("t2_ready_still_low", ready, 0);
    tick();
    @(negedge clk); chk("t2_ready_back", ready, 1);
    wait_n(2);
    chk("t2_one_commit", ctags.size(), 1);
    for (int k = 1; k < 16; k += 3) begin
      set_cmp(0, k); set_cmp(1, k + 1); set_cmp(2, (k + 2) % 16); tick();
    end
    wait_n(20);
    chk("t2_drained", ctags.size(), 16);

    // 3. out-of-order completion retires in order
    do_reset();
    do_alloc(1, 8, 1); do_alloc(1, 9, 2); do_alloc(1, 10, 3);
    set_cmp(0, 2); tick();
    set_cmp(2, 1); tick();
    wait_n(3);
    chk("t3_blocked", ctags.size(), 0);
    set_cmp(1, 0); tick();
    wait_n(5);
    chk("t3_count", ctags.size(), 3);
    if (ctags.size() == 3) begin
      chk("t3_order0", ctags[0], 0); chk("t3_order1", ctags[1], 1); chk("t3_order2", ctags[2], 2);
    end

    // 4. partial flush from tag 3 (with a dropped same-cycle alloc)
    do_reset();
    for (int k = 0; k < 6; k++) do_alloc(1, 10 + k, 30 + k);
    rec = 1; rtag = 4'd3; set_alloc(1, 50, 51); tick();
    chk("t4_model_count", mq.size(), 3);
    chk("t4_model_tail", m_tail, 3);
    set_cmp(1, 4); tick();
    do_alloc(1, 20, 60);
    set_cmp(0, 0); set_cmp(1, 1); set_cmp(2, 2); tick();
    set_cmp(0, 3); tick();
    wait_n(8);
    chk("t4_commits", ctags.size(), 4);
    if (ctags.size() == 4) chk("t4_last_tag", ctags[3], 3);
    chk("t4_frees", frees.size(), 4);
    if (frees.size() == 4) chk("t4_realloc_free", frees[3], 20);

    // 5. flush at head blocks a ready commit; then wrap 40 times through 15->0
    do_reset();
    do_alloc(1, 3, 4); do_alloc(1, 5, 6);
    set_cmp(0, 0); tick();
    rec = 1; rtag = 4'd0; tick();
    @(negedge clk); chk("t5_empty", empty, 1);
    wait_n(3);
    chk("t5_no_commit", ctags.size(), 0);
    for (int k = 0; k < 40; k++) begin
      set_alloc(1, (k % 60) + 1, k % 64);
      if (k > 0) set_cmp(0, (m_tail + 15) % 16);
      tick();
    end
    set_cmp(0, (m_tail + 15) % 16); tick();
    wait_n(6);
    chk("t5_wrap_commits", ctags.size(), 40);
    if (ctags.size() == 40) begin
      chk("t5_tag15", ctags[15], 15); chk("t5_tag16", ctags[16], 0); chk("t5_tag39", ctags[39], 7);
    end

    // 6. no free for rd_used=0 or old_p=0
    do_reset();
    do_alloc(0, 9, 30); do_alloc(1, 0, 31);
    set_cmp(0, 0); set_cmp(1, 1); tick();
    wait_n(6);
    chk("t6_commits", ctags.size(), 2);
    chk("t6_no_frees", frees.size(), 0);

    // 7. reset while commits are ready: no free pulse
    do_reset();
    do_alloc(1, 11, 1); do_alloc(1, 12, 2);
    set_cmp(0, 0); set_cmp(1, 1); tick();
    rst = 1; tick(); tick(); rst = 0;
    wait_n(4);
    chk("t7_no_frees", frees.size(), 0);
    chk("t7_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
